// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// fetch_unit : pipelined instruction fetch front end with an in-order reservation
//              queue and redirect flush. Macro FETCH_PERF_EN enables perf counters.
// Rev 1.0
// =============================================================================
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              QDEPTH       = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pc4_o,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
);
    localparam int              AW                = $clog2(QDEPTH);
    localparam int              CW                = AW + 1;
    localparam logic [CW-1:0]   C_QDEPTH          = CW'(QDEPTH);
    localparam logic [CW:0]     C_MAX_OUTSTANDING = (CW + 1)'(2 * QDEPTH - 1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [AW-1:0]     fill_ptr_q, fill_ptr_d;
    logic [AW-1:0]     head_ptr_q, head_ptr_d;
    logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [QDEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]   slot_pc_q   [QDEPTH];
    logic [31:0]       slot_data_q [QDEPTH];

    logic pop, req_fire, rsp_known, rsp_drop, rsp_fill, has_room, below_cap;

    assign instr_valid_o = filled_q[head_ptr_q] & ~redirect_i;
    assign pop           = instr_valid_o & instr_ready_i;
    assign instr_o       = slot_data_q[head_ptr_q];
    assign instr_pc_o    = slot_pc_q[head_ptr_q];
    assign instr_pc4_o   = instr_pc_o + XLEN'(4);

    // Capping total memory-owed responses keeps discard_q from ever overflowing
    // under repeated redirects.
    assign has_room         = (alloc_cnt_q < C_QDEPTH) | pop;
    assign below_cap        = ({1'b0, discard_q} + {1'b0, inflight_q}) < C_MAX_OUTSTANDING;
    assign imem_req_valid_o = rst_ni & ~redirect_i & has_room & below_cap;
    assign imem_addr_o      = fetch_pc_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    assign rsp_known = imem_rsp_valid_i & ((discard_q != '0) | (inflight_q != '0));
    assign rsp_drop  = rsp_known & (discard_q != '0);
    assign rsp_fill  = rsp_known & (discard_q == '0) & ~redirect_i;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        inflight_d  = inflight_q;
        discard_d   = discard_q;
        filled_d    = filled_q;
        if (redirect_i) begin
            fetch_pc_d  = redirect_pc_i & ~XLEN'(3);
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            alloc_cnt_d = '0;
            inflight_d  = '0;
            filled_d    = '0;
            // Everything still owed by memory after this cycle must be dropped.
            discard_d   = discard_q + inflight_q - CW'(rsp_known);
        end else begin
            if (req_fire) begin
                fetch_pc_d  = fetch_pc_q + XLEN'(4);
                alloc_ptr_d = alloc_ptr_q + AW'(1);
            end
            if (rsp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + AW'(1);
            end
            if (pop) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + AW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(req_fire) - CW'(pop);
            inflight_d  = inflight_q + CW'(req_fire) - CW'(rsp_fill);
            discard_d   = discard_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q  <= RESET_VECTOR;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            filled_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            filled_q    <= filled_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            slot_pc_q[alloc_ptr_q] <= fetch_pc_q;
        end
        if (rsp_fill) begin
            slot_data_q[fill_ptr_q] <= imem_rsp_data_i;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (redirect_i) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    assign perf_fetch_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

`ifndef SYNTHESIS
    a_no_unsolicited_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rsp_valid_i && (discard_q == '0) && (inflight_q == '0)));
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation RV32I core, replacing the fixed "pc <= pc+4 / alu_data" register and the direct instruction-memory read. It issues pipelined requests to a variable-latency instruction memory and keeps up to QDEPTH instructions in a reservation queue. It delivers {instr, pc, pc+4} to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, PC/address width
RESET_VECTOR, 32'h0000_0000, fetch PC after reset (bits [1:0] must be 0)
QDEPTH, 4, reservation-queue slots = max outstanding plus buffered instructions; power of 2, >=2

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  memory accepts request
imem_addr_o  out  XLEN  request address (word aligned)
imem_rsp_valid_i  in  1  response valid; responses return in request order, min 1 cycle after accept
imem_rsp_data_i  in  32  response instruction word
redirect_i  in  1  taken branch/jump/trap: flush and restart
redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 00
instr_valid_o  out  1  head instruction valid
instr_ready_i  in  1  decode consumes head
instr_o  out  32  head instruction
instr_pc_o  out  XLEN  PC of head instruction
instr_pc4_o  out  XLEN  instr_pc_o + 4 (mod 2^XLEN)
perf_fetch_cnt_o  out  32  delivered-instruction count (see Optional Feature)
perf_flush_cnt_o  out  32  redirect count (see Optional Feature)

Behaviour:
- Reset (async assert): fetch_pc=RESET_VECTOR, all slot valid/filled bits 0, alloc/fill/head pointers 0, discard_cnt 0. Outputs: instr_valid_o=0, imem_req_valid_o=0 while rst_ni low, perf counters 0. Reset mid-transaction drops everything; the memory is reset on the same signal, so nothing is discarded afterward.
- Request: imem_req_valid_o = (allocated < QDEPTH) & ~redirect_i. imem_addr_o = fetch_pc. On handshake, a slot is allocated at alloc_ptr and stores the PC, with filled=0. fetch_pc += 4, alloc_ptr++ (wraps mod QDEPTH).
- allocated counts slots holding requested-not-consumed entries. A same-cycle pop and request is allowed even when allocated == QDEPTH-1 or QDEPTH: the pop frees a slot in the same cycle for the full check.
- Response: if discard_cnt > 0, drop it and decrement. Otherwise write data into the slot at fill_ptr, set filled, fill_ptr++.
- Output: instr_valid_o = head slot filled & ~redirect_i. instr_o, instr_pc_o and instr_pc4_o come from the head slot registers. A response is visible at the earliest 1 cycle after imem_rsp_valid_i (registered). The pop is instr_valid_o & instr_ready_i: head_ptr++, slot cleared.
- Outputs hold stable while valid & ~ready.
- Redirect (highest priority): no request, no pop, and any response this cycle is dropped. Next state:
  - all slots cleared, pointers 0
  - fetch_pc = {redirect_pc_i[XLEN-1:2],2'b00}
  - discard_cnt = current_inflight - (imem_rsp_valid_i & discard_cnt==0 ? 1 : 0) + (discard_cnt>0 ? discard_cnt - imem_rsp_valid_i : 0)
  - i.e. every response still owed afterwards is discarded.
  - inflight = allocated-but-unfilled slots; discard_cnt width clog2(QDEPTH)+1.
- Requests may issue in the cycle after a redirect, even while discard_cnt > 0. New slots fill only after discards complete, which in-order responses guarantee.
- Back-to-back redirects: each recomputes discard_cnt from the current state; the last redirect PC wins.
- PC arithmetic wraps modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0.
- An unsolicited response (inflight==0 and discard_cnt==0) is a protocol error: ignored, no state change; an assertion fires in simulation.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: perf_fetch_cnt_o increments on each pop; perf_flush_cnt_o increments on each redirect cycle. Both are 32-bit, wrap on overflow and reset to 0.
- Undefined: no counter flops; both ports are tied to 32'h0.

Test Plan:
- Reset release, imem always ready, 1-cycle latency, decode always ready -> addresses 0x0,0x4,0x8,... and one instr per cycle steady state, with instr_pc4_o = instr_pc_o+4.
- instr_ready_i held 0 -> exactly QDEPTH=4 requests issued, then imem_req_valid_o=0. Outputs stable on the first instruction (pc 0x0) until ready, then one new request per pop.
- Latency 3, redirect_i with redirect_pc_i=0x103 while 2 requests are in flight -> next request address 0x100, 2 responses dropped, first delivered instr_pc_o=0x100.
- Redirect coincident with a response and a pop -> pop not taken, response dropped, discard_cnt equals remaining inflight, perf_flush_cnt_o +1 (FETCH_PERF_EN).
- Redirect to 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_ni asserted mid-burst with 3 inflight -> instr_valid_o=0 immediately (async), first request after release at RESET_VECTOR, no responses discarded.
